// File: rtl/sm_hex_scanner.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Optional leading-zero blanking is enabled by defining SM_HEX_SCAN_LZB_EN.
module sm_hex_scanner #(
    parameter int DIGITS     = 8,
    parameter int PRESCALE   = 50000,
    parameter int GAP_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] value,
    input  logic                load,
    output logic [3:0]          digit,
    output logic [DIGITS-1:0]   anodes,
    output logic                frame
);

    localparam int CNT_MAX = (PRESCALE > GAP_CYCLES) ? PRESCALE : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(DIGITS);

    localparam logic [CW-1:0] PRE_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam bit            HAS_GAP  = (GAP_CYCLES > 0);

    typedef enum logic {
        GAP,
        SHOW
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] pending_q;
    logic [4*DIGITS-1:0] active_q, active_d;
    logic                wrap;
    logic                blank;
    logic [DIGITS-1:0]   anodes_d;
    logic [3:0]          digit_d;

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        wrap    = 1'b0;

        case (state_q)
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (cnt_q == PRE_LAST) begin
                    cnt_d   = '0;
                    wrap    = (idx_q == IDX_LAST);
                    idx_d   = wrap ? '0 : idx_q + 1'b1;
                    state_d = HAS_GAP ? GAP : SHOW;
                end
            end
            default: begin
                state_d = GAP;
                cnt_d   = '0;
            end
        endcase

        // The frame wrap swaps in the pending value, so the next digit's
        // nibble and blanking must already see the new contents.
        active_d = wrap ? pending_q : active_q;
    end

`ifdef SM_HEX_SCAN_LZB_EN
    logic [DIGITS-1:0] upper_zero;

    // upper_zero[i] is set when nibbles i..DIGITS-1 are all zero.
    always_comb begin
        upper_zero             = '0;
        upper_zero[DIGITS-1]   = (active_d[4*(DIGITS-1) +: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (active_d[4*i +: 4] == 4'h0);
        end
        blank = (idx_d != '0) && upper_zero[idx_d];
    end
`else
    always_comb begin
        blank = 1'b0;
    end
`endif

    always_comb begin
        digit_d  = active_d[4*int'(idx_d) +: 4];
        anodes_d = '1;
        if (state_d == SHOW && !blank) begin
            anodes_d[idx_d] = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= GAP;
            cnt_q     <= '0;
            idx_q     <= '0;
            pending_q <= '0;
            active_q  <= '0;
            anodes    <= '1;
            digit     <= 4'h0;
            frame     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            active_q <= active_d;
            anodes   <= anodes_d;
            digit    <= digit_d;
            frame    <= wrap;
            if (load) begin
                pending_q <= value;
            end
        end
    end

endmodule

// File: tb/tb_sm_hex_scanner.sv
// Self-checking bench for sm_hex_scanner (DIGITS=4, PRESCALE=4, GAP_CYCLES=1),
// plus a second instance with GAP_CYCLES=0 for the gapless frame period.
module tb_sm_hex_scanner;

    localparam int DIGITS    = 4;
    localparam int PRESCALE  = 4;
    localparam int GAP       = 1;
    localparam int PERIOD    = PRESCALE + GAP;
    localparam int FRAME_LEN = DIGITS * PERIOD;

`ifdef SM_HEX_SCAN_LZB_EN
    localparam logic [3:0] LIT_ZERO = 4'b0001;
    localparam logic [3:0] LIT_0030 = 4'b0011;
    localparam logic [3:0] LIT_0400 = 4'b0111;
`else
    localparam logic [3:0] LIT_ZERO = 4'b1111;
    localparam logic [3:0] LIT_0030 = 4'b1111;
    localparam logic [3:0] LIT_0400 = 4'b1111;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        load  = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  digit, anodes;
    logic        frame;
    logic [3:0]  digit0, anodes0;
    logic        frame0;

    always #5 clk = ~clk;

    sm_hex_scanner #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load),
        .digit(digit), .anodes(anodes), .frame(frame)
    );

    sm_hex_scanner #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .GAP_CYCLES(0)) dut_nogap (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load),
        .digit(digit0), .anodes(anodes0), .frame(frame0)
    );

    // Expected frame contents: the displayed value and which digits light up.
    typedef struct {
        logic [15:0] value;
        logic [3:0]  lit;
    } frame_exp_t;

    frame_exp_t vec[5];
    frame_exp_t frame_q[$];
    frame_exp_t m_pending;
    int         checks   = 0;
    int         failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock edge; the frame shown next is queued at the wrap edge,
    // before any load on that same edge can affect it.
    task automatic drive_edge(input bit do_load, input frame_exp_t v, input bit is_wrap);
        if (is_wrap) frame_q.push_back(m_pending);
        if (do_load) m_pending = v;
        value = v.value;
        load  = do_load;
        tick();
        load  = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        load  = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            check($sformatf("reset%0d anodes", i), anodes, 4'hF);
            check($sformatf("reset%0d digit", i), digit, 4'h0);
            check($sformatf("reset%0d frame", i), frame, 1'b0);
        end
        rst_n = 1'b1;
        m_pending = frame_exp_t'{16'h0, LIT_ZERO};
        frame_q.delete();
        frame_q.push_back(m_pending);
    endtask

    // Walks n cycles of a frame starting at its first GAP cycle.
    task automatic check_frame(input bit first_pulse, input int load_at,
                               input frame_exp_t lv, input int n);
        frame_exp_t e;
        logic [3:0] exp_an;
        int         s, o;
        if (frame_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: no expected frame queued");
            e = frame_exp_t'{16'h0, 4'hF};
        end else begin
            e = frame_q.pop_front();
        end
        for (int k = 0; k < n; k++) begin
            s = k / PERIOD;
            o = k % PERIOD;
            exp_an = 4'hF;
            if (o >= GAP && e.lit[s]) exp_an[s] = 1'b0;
            check($sformatf("v%h k%0d frame", e.value, k), frame, (k == 0) && first_pulse);
            check($sformatf("v%h k%0d anodes", e.value, k), anodes, exp_an);
            check($sformatf("v%h k%0d digit", e.value, k), digit, e.value[4*s +: 4]);
            drive_edge(k == load_at, lv, k == FRAME_LEN - 1);
        end
    endtask

    task automatic wait_frame0(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!frame0 && n < budget);
        check("nogap frame wait", frame0, 1'b1);
    endtask

    initial begin
        int n, blanks;
        frame_exp_t dummy;
        dummy  = frame_exp_t'{16'h0, 4'hF};
        vec[0] = frame_exp_t'{16'h1A2F, 4'b1111};
        vec[1] = frame_exp_t'{16'h0030, LIT_0030};
        vec[2] = frame_exp_t'{16'h0000, LIT_ZERO};
        vec[3] = frame_exp_t'{16'h8007, 4'b1111};
        vec[4] = frame_exp_t'{16'h0400, LIT_0400};

        do_reset(3);
        // Frame 0 shows zeros while 1A2F is captured on its first edge.
        check_frame(1'b0, 0, vec[0], FRAME_LEN);
        for (int i = 1; i < 5; i++) begin
            check_frame(1'b1, 7, vec[i], FRAME_LEN);
        end

        // Mid-frame load while digit 2 is lit, then a load on the wrap edge.
        check_frame(1'b1, 7, vec[0], FRAME_LEN);
        check_frame(1'b1, 12, frame_exp_t'{16'h5555, 4'hF}, FRAME_LEN);
        check_frame(1'b1, FRAME_LEN - 1, frame_exp_t'{16'h1234, 4'hF}, FRAME_LEN);
        check_frame(1'b1, -1, dummy, FRAME_LEN);

        // Reset in the middle of digit 2's SHOW phase.
        check_frame(1'b1, -1, dummy, 2 * PERIOD + GAP);
        check("midshow anodes", anodes, 4'b1011);
        check("midshow digit", digit, 4'h2);
        do_reset(1);
        check_frame(1'b0, -1, dummy, FRAME_LEN);
        check_frame(1'b1, -1, dummy, FRAME_LEN);

        // Gapless instance: 16-cycle frame and no dark cycles between digits.
        value = 16'h1111;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        wait_frame0(40);
        wait_frame0(40);
        check("nogap pulse digit", digit0, 4'h1);
        n      = 0;
        blanks = 0;
        do begin
            tick();
            n++;
            if (anodes0 == 4'hF) blanks++;
        end while (!frame0 && n < 40);
        check("nogap frame period", n, 16);
        check("nogap dark cycles", blanks, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
